bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one port of true_dual_port_wf_bram between NUM_REQ requesters.
//  - Per cycle: grants at most one valid/ready request (read or write) and drives the BRAM port.
//  - Routes the 1-cycle-latency BRAM read data back to the granted requester, tagged by rsp_valid_o.
//  - Sits between client engines and the BRAM; one instance per BRAM port.
// PARAMETERS
//  NUM_REQ        4   number of requesters, 2..16
//  RAM_WIDTH      8   data width, matches BRAM RAM_WIDTH
//  RAM_ADDR_BITS  10  address width, matches BRAM RAM_ADDR_BITS
// PORTS
//  clk_i        in   1                        clock, all logic on posedge
//  arstn_i      in   1                        asynchronous active-low reset
//  req_valid_i  in   NUM_REQ                  request valid per requester
//  req_ready_o  out  NUM_REQ                  one-hot grant; transfer when valid & ready
//  req_we_i     in   NUM_REQ                  1 = write, 0 = read, per requester
//  req_addr_i   in   NUM_REQ*RAM_ADDR_BITS    packed addresses, requester k at [k*RAM_ADDR_BITS +: RAM_ADDR_BITS]
//  req_wdata_i  in   NUM_REQ*RAM_WIDTH        packed write data, same packing as req_addr_i
//  rsp_valid_o  out  NUM_REQ                  one-hot; rsp_data_o valid for that requester
//  rsp_data_o   out  RAM_WIDTH                BRAM read data, broadcast to all requesters
//  bram_en_o    out  1                        to BRAM en
//  bram_we_o    out  1                        to BRAM we
//  bram_addr_o  out  RAM_ADDR_BITS            to BRAM addr
//  bram_data_o  out  RAM_WIDTH                to BRAM write data
//  bram_data_i  in   RAM_WIDTH                from BRAM read data
// BEHAVIOUR
//  Reset values (async, while arstn_i = 0)
//  - prio_ptr = 0; rsp_valid_o = 0; rsp_id = 0.
//  - Combinational outputs follow from inputs: req_ready_o = 0 only if no valid.
//  Arbitration (combinational, same cycle)
//  - Search starts at prio_ptr and wraps modulo NUM_REQ.
//  - First k with req_valid_i[k] = 1 gets req_ready_o[k] = 1; all other ready bits are 0.
//  - No valid: req_ready_o = 0, bram_en_o = 0, bram_we_o = 0.
//  - bram_addr_o and bram_data_o are don't-care but held stable; they mux index 0.
//  - On grant g: bram_en_o = 1, bram_we_o = req_we_i[g], addr/data = slice g.
//  Sequential updates
//  - Grant g in cycle N: prio_ptr <= (g == NUM_REQ-1) ? 0 : g+1. No grant: prio_ptr unchanged.
//  - Grant g in cycle N: rsp_valid_o = onehot(g) in cycle N+1, reads and writes alike.
//  - A write response returns the written data (BRAM is write-first).
//  - rsp_data_o = bram_data_i, passed through combinationally; the BRAM output register provides the latency.
//  - No grant in cycle N: rsp_valid_o = 0 in N+1.
//  - Back-to-back grants allowed every cycle; throughput is 1 request/cycle; no stalls.
//  Fairness
//  - A continuously valid requester waits at most NUM_REQ-1 cycles for a grant.
//  Requester obligations
//  - Requester holds valid/we/addr/wdata stable until ready.
//  - Arbiter does not check this; a dropped valid simply loses its turn.
//  Boundaries
//  - Single requester: granted every cycle.
//  - All valid: strict rotation 0,1,..,NUM_REQ-1,0.
//  - Reset mid-operation: the in-flight response is discarded (rsp_valid_o forced 0) and prio_ptr returns to 0.
//  - Same-address access from the BRAM's other port is outside this block's scope.
// STRUCTURE
//  Package bram_arb_pkg
//  - localparam function clog2-based ID width.
//  - typedef for requester index.
//  - Function rr_pick(valid, ptr) returning index plus found flag.
//  Sub-module rr_priority_encoder
//  - Combinational: rotate, priority-encode, un-rotate.
//  - Instantiated once.
//  Top level holds prio_ptr, rsp_id/rsp_valid registers and the request muxes.
// TESTING (NUM_REQ = 4, W = 8, A = 10, BRAM instantiated behind arbiter)
//  1 reset
//    - Stimulus: arstn_i = 0 with all req_valid_i = 1.
//    - Response: rsp_valid_o = 0; after release first grant is req 0.
//  2 single write/read
//    - Stimulus: req2 writes 0xA5 @ 3, then reads @ 3.
//    - Response: write rsp_valid_o = 4'b0100 with data A5 at N+1; read returns A5 one cycle after grant.
//  3 all valid continuously for 8 cycles
//    - Response: grants 0,1,2,3,0,1,2,3.
//    - Response: each rsp_valid_o one-hot one cycle after its grant.
//  4 pointer skip
//    - Stimulus: ptr at 1, only req0 and req3 valid.
//    - Response: grant 3, then 0, then 3.
//  5 reset mid-operation
//    - Stimulus: assert arstn_i low in the cycle after a read grant.
//    - Response: rsp_valid_o drops to 0 immediately; ptr = 0 after release.
//  6 random mix
//    - Stimulus: 1000 cycles, addr in [0:5], we 80%.
//    - Response: scoreboard model of memory matches every rsp_data_o.
//    - Response: no requester waits more than 3 cycles.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// ----------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and helpers for the BRAM port arbiter.
//   MAX_REQ    : largest supported requester count (index type is sized for it)
//   id_width() : clog2-based width helper (minimum 1 bit)
//   req_idx_t  : requester index type
//   rr_pick()  : round-robin pick over a valid vector, returns {found, idx}
// ----------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ID_W = id_width(MAX_REQ);

  typedef logic [ID_W-1:0] req_idx_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } rr_pick_t;

  // First set bit of valid[0 +: n], searching from ptr upward and wrapping
  // modulo n. ptr must be below n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input req_idx_t ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned pos;
    req_idx_t    j;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        pos = 32'(ptr) + i;
        if (pos >= n) pos = pos - n;
        j = req_idx_t'(pos);
        if (!res.found && valid[j]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// ----------------------------------------------------------------------------
// rr_priority_encoder
// Combinational round-robin selector: rotates the valid vector so that the
// priority pointer lands on bit 0, priority-encodes the lowest set bit, then
// un-rotates the index back into requester numbering.
//   valid_i [NUM_REQ] : request valid per requester
//   ptr_i             : requester with highest priority this cycle (< NUM_REQ)
//   grant_o [NUM_REQ] : one-hot grant, zero when nothing is valid
//   idx_o             : granted requester index, 0 when nothing is valid
//   found_o           : a grant was issued
// ----------------------------------------------------------------------------
module rr_priority_encoder
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_idx_t           ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_t           idx_o,
  output logic               found_o
);

  localparam int unsigned SEL_W = id_width(2 * NUM_REQ);

  typedef logic [ID_W:0] sum_t;

  // Doubling the vector turns the rotation into a plain indexed pick.
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  rr_pick_t             enc;
  sum_t                 unrot_sum;

  assign dbl_valid = {valid_i, valid_i};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [SEL_W-1:0] sel;
    assign sel           = SEL_W'(gi) + SEL_W'(ptr_i);
    assign rot_valid[gi] = dbl_valid[sel];
  end

  // Rotated vector is searched from bit 0: a plain priority encoder.
  assign enc = rr_pick(MAX_REQ'(rot_valid), '0, NUM_REQ);

  assign unrot_sum = {1'b0, enc.idx} + {1'b0, ptr_i};

  always_comb begin
    idx_o   = '0;
    found_o = enc.found;
    if (enc.found) begin
      if (unrot_sum >= sum_t'(NUM_REQ)) idx_o = req_idx_t'(unrot_sum - sum_t'(NUM_REQ));
      else                              idx_o = req_idx_t'(unrot_sum);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_o[gi] = found_o && (idx_o == req_idx_t'(gi));
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// bram_port_arbiter
// Round-robin arbiter sharing one port of a write-first BRAM between NUM_REQ
// requesters. At most one request is granted per cycle; the BRAM's registered
// read data is routed back one cycle later, tagged with a one-hot rsp_valid_o.
//   clk_i, arstn_i           : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : per-requester handshake, ready is one-hot grant
//   req_we_i, req_addr_i,
//   req_wdata_i              : packed request fields, requester k at slice k
//   rsp_valid_o, rsp_data_o  : one-hot response tag, broadcast read data
//   bram_en_o, bram_we_o,
//   bram_addr_o, bram_data_o : BRAM port drive
//   bram_data_i              : BRAM registered read data
// ----------------------------------------------------------------------------
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 10
) (
  input  logic                             clk_i,
  input  logic                             arstn_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr_i,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [RAM_WIDTH-1:0]             rsp_data_o,
  output logic                             bram_en_o,
  output logic                             bram_we_o,
  output logic [RAM_ADDR_BITS-1:0]         bram_addr_o,
  output logic [RAM_WIDTH-1:0]             bram_data_o,
  input  logic [RAM_WIDTH-1:0]             bram_data_i
);

  localparam req_idx_t LAST_IDX = req_idx_t'(NUM_REQ - 1);

  req_idx_t prio_q, prio_d;
  req_idx_t rsp_id_q, rsp_id_d;
  logic     rsp_vld_q, rsp_vld_d;

  req_idx_t grant_idx;
  logic     grant_found;

  // Request fields unpacked into MAX_REQ-deep tables so the full-width
  // requester index selects them directly; unused entries read as zero.
  logic [RAM_ADDR_BITS-1:0] addr_arr  [MAX_REQ];
  logic [RAM_WIDTH-1:0]     wdata_arr [MAX_REQ];
  logic [MAX_REQ-1:0]       we_ext;

  assign we_ext = MAX_REQ'(req_we_i);

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign addr_arr[gi]  = req_addr_i[gi*RAM_ADDR_BITS +: RAM_ADDR_BITS];
      assign wdata_arr[gi] = req_wdata_i[gi*RAM_WIDTH +: RAM_WIDTH];
    end else begin : g_unused
      assign addr_arr[gi]  = '0;
      assign wdata_arr[gi] = '0;
    end
  end

  rr_priority_encoder #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_enc (
    .valid_i (req_valid_i),
    .ptr_i   (prio_q),
    .grant_o (req_ready_o),
    .idx_o   (grant_idx),
    .found_o (grant_found)
  );

  // grant_idx is 0 when idle, so the address/data muxes park on requester 0.
  assign bram_en_o   = grant_found;
  assign bram_we_o   = grant_found & we_ext[grant_idx];
  assign bram_addr_o = addr_arr[grant_idx];
  assign bram_data_o = wdata_arr[grant_idx];

  // The BRAM output register supplies the one-cycle latency.
  assign rsp_data_o = bram_data_i;

  always_comb begin
    prio_d    = prio_q;
    rsp_vld_d = grant_found;
    rsp_id_d  = grant_idx;
    if (grant_found) begin
      prio_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      prio_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid_o[gi] = rsp_vld_q && (rsp_id_q == req_idx_t'(gi));
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed and random checks of bram_port_arbiter with a write-first BRAM
// model behind it (NUM_REQ = 4, 8-bit data, 10-bit address).
// ----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int A = 10;

  logic           clk = 1'b0;
  logic           arstn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_we;
  logic [N*A-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           bram_en;
  logic           bram_we;
  logic [A-1:0]   bram_addr;
  logic [W-1:0]   bram_wdata;
  logic [W-1:0]   bram_q;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] sb [0:(1<<A)-1];

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NUM_REQ       (N),
    .RAM_WIDTH     (W),
    .RAM_ADDR_BITS (A)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .bram_en_o   (bram_en),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_data_o (bram_wdata),
    .bram_data_i (bram_q)
  );

  // Write-first BRAM with registered output.
  logic [W-1:0] mem [0:(1<<A)-1];
  initial begin
    for (int i = 0; i < (1<<A); i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] = bram_wdata;
        bram_q <= bram_wdata;
      end else begin
        bram_q <= mem[bram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [A-1:0] a, input logic [W-1:0] d);
    req_valid[k]       = v;
    req_we[k]          = w;
    req_addr[k*A +: A] = a;
    req_wdata[k*W +: W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] w;
    logic [A-1:0] ra [N];
    logic [W-1:0] rd [N];
    int           waitc [N];
    int           mptr;
    int           g;
    int           j;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;

    for (int i = 0; i < (1<<A); i++) sb[i] = '0;
    arstn     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // ---- 1: reset with all requesters valid ----
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(4'b0000));
    chk("rst_ready",     32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("rel_first_grant", 32'(req_ready), 32'(4'b0001));
    $display("reset released: grant req0");
    tick();
    chk("rel_rsp_valid",  32'(rsp_valid), 32'(4'b0001));
    chk("rel_next_grant", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'(0));
    chk("idle_en",    32'(bram_en),   32'(0));
    chk("idle_we",    32'(bram_we),   32'(0));
    tick();
    chk("idle_rsp", 32'(rsp_valid), 32'(0));

    // ---- 2: req2 writes A5 @3 then reads it back ----
    set_req(2, 1'b1, 1'b1, 10'd3, 8'hA5);
    #1;
    chk("wr_ready", 32'(req_ready),  32'(4'b0100));
    chk("wr_en",    32'(bram_en),    32'(1));
    chk("wr_we",    32'(bram_we),    32'(1));
    chk("wr_addr",  32'(bram_addr),  32'(3));
    chk("wr_data",  32'(bram_wdata), 32'(8'hA5));
    sb[3] = 8'hA5;
    $display("req2 write addr 3 data a5");
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    chk("wr_rsp_data",  32'(rsp_data),  32'(8'hA5));
    set_req(2, 1'b1, 1'b0, 10'd3, 8'h00);
    #1;
    chk("rd_ready", 32'(req_ready), 32'(4'b0100));
    chk("rd_we",    32'(bram_we),   32'(0));
    chk("rd_addr",  32'(bram_addr), 32'(3));
    $display("req2 read addr 3");
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    chk("rd_rsp_data",  32'(rsp_data),  32'(8'hA5));
    set_req(2, 1'b0, 1'b0, 10'd0, 8'h00);

    // ---- wrap: pointer sits at 3, grant 3 moves it to 0 ----
    set_req(3, 1'b1, 1'b0, 10'd3, 8'h00);
    #1;
    chk("wrap_grant", 32'(req_ready), 32'(4'b1000));
    $display("req3 read addr 3");
    tick();
    chk("wrap_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
    chk("wrap_rsp_data",  32'(rsp_data),  32'(8'hA5));
    set_req(3, 1'b0, 1'b0, 10'd0, 8'h00);

    // ---- 3: all valid for 8 cycles, strict rotation ----
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, A'(k), 8'h00);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rot_grant", 32'(req_ready), 32'(1 << (i % N)));
      if (i > 0) begin
        chk("rot_rsp_valid", 32'(rsp_valid), 32'(1 << ((i - 1) % N)));
        chk("rot_rsp_data",  32'(rsp_data),  32'(sb[(i - 1) % N]));
      end
      $display("rotation cycle %0d grant %0d", i, i % N);
      tick();
    end
    chk("rot_last_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
    chk("rot_last_rsp_data",  32'(rsp_data),  32'(8'hA5));
    req_valid = '0;

    // ---- 4: pointer skip with only req0 and req3 valid ----
    set_req(0, 1'b1, 1'b1, 10'd5, 8'h3C);
    #1;
    chk("skip_pre_grant", 32'(req_ready), 32'(4'b0001));
    sb[5] = 8'h3C;
    $display("req0 write addr 5 data 3c");
    tick();
    chk("skip_pre_rsp", 32'(rsp_data), 32'(8'h3C));
    set_req(0, 1'b1, 1'b0, 10'd5, 8'h00);
    set_req(3, 1'b1, 1'b0, 10'd3, 8'h00);
    #1;
    chk("skip_grant_a", 32'(req_ready), 32'(4'b1000));
    $display("skip grant 3");
    tick();
    chk("skip_rsp_a",   32'(rsp_valid), 32'(4'b1000));
    chk("skip_grant_b", 32'(req_ready), 32'(4'b0001));
    $display("skip grant 0");
    tick();
    chk("skip_rsp_b",      32'(rsp_valid), 32'(4'b0001));
    chk("skip_rsp_b_data", 32'(rsp_data),  32'(8'h3C));
    chk("skip_grant_c",    32'(req_ready), 32'(4'b1000));
    $display("skip grant 3");
    tick();
    chk("skip_rsp_c", 32'(rsp_valid), 32'(4'b1000));
    req_valid = '0;

    // ---- 5: reset in the cycle after a read grant ----
    set_req(1, 1'b1, 1'b0, 10'd5, 8'h00);
    #1;
    chk("mid_grant", 32'(req_ready), 32'(4'b0010));
    $display("req1 read addr 5");
    tick();
    set_req(1, 1'b0, 1'b0, 10'd0, 8'h00);
    chk("mid_rsp_before", 32'(rsp_valid), 32'(4'b0010));
    arstn = 1'b0;
    #1;
    chk("mid_rsp_dropped", 32'(rsp_valid), 32'(0));
    tick();
    @(negedge clk);
    arstn     = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'(4'b0001));
    $display("reset released: grant req0");
    tick();
    req_valid = '0;
    chk("mid_rsp_after", 32'(rsp_valid), 32'(4'b0001));
    tick();

    // ---- 6: random mix against a memory scoreboard ----
    mptr   = 1;
    v      = '0;
    w      = '0;
    exp_rv = '0;
    exp_rd = '0;
    for (int k = 0; k < N; k++) begin
      ra[k] = '0; rd[k] = '0; waitc[k] = 0;
    end
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && ($urandom_range(0, 9) < 6)) begin
          v[k]     = 1'b1;
          w[k]     = ($urandom_range(0, 9) < 8);
          ra[k]    = A'($urandom_range(0, 5));
          rd[k]    = W'($urandom_range(0, 255));
          waitc[k] = 0;
        end
        set_req(k, v[k], w[k], ra[k], rd[k]);
      end
      g = -1;
      for (int i = 0; i < N; i++) begin
        j = (mptr + i) % N;
        if (g < 0 && v[j]) g = j;
      end
      @(negedge clk);
      chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'(0));
      chk("rnd_en",    32'(bram_en),   (g >= 0) ? 32'(1) : 32'(0));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) chk("rnd_rsp_data", 32'(rsp_data), 32'(exp_rd));
      exp_rv = '0;
      if (g >= 0) begin
        chk("rnd_wait_bound", 32'(waitc[g] <= N - 1), 32'(1));
        exp_rv = N'(1 << g);
        if (w[g]) begin
          sb[ra[g]] = rd[g];
          exp_rd    = rd[g];
        end else begin
          exp_rd = sb[ra[g]];
        end
        $display("rnd cycle %0d grant %0d %s addr %0d data %02h waited %0d",
                 c, g, w[g] ? "wr" : "rd", ra[g], exp_rd, waitc[g]);
        v[g] = 1'b0;
        mptr = (g + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
        if (v[k] && k != g) waitc[k]++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    #1;
    chk("rnd_final_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) chk("rnd_final_rsp_data", 32'(rsp_data), 32'(exp_rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
